// File: rtl/sha3512_digest_reader.sv
// sha3512_digest_reader
//
// Squeeze-side reader for the SHA3-512 coprocessor. On a capture request it
// snapshots the 512-bit digest (bits [511:0] of the Keccak state) into a
// private shadow register. It then streams the digest out as WORD_W-bit words
// over a valid/ready handshake. Because the shadow register is private, the
// round register and keccak-p core may start on the next message as soon as
// the capture edge has passed.
//
// Parameters
//   WORD_W    : output word width, 32 or 64 (N = 512/WORD_W words per digest)
//   BYTE_SWAP : 1 = reverse byte order inside each output word
//
// Ports
//   inClk     : clock, rising edge
//   inRst     : asynchronous active-high reset
//   inInit    : synchronous clear, same effect as reset
//   inCapture : one-cycle snapshot request, honoured only when idle
//   inState   : 1600-bit Keccak state, only [511:0] used
//   outBusy   : high while a digest is being streamed
//   outValid  : outData holds a valid word
//   outData   : current digest word, zero when not valid
//   inReady   : downstream accepts the word this cycle
//   outLast   : final word of the digest is presented
//   outDone   : one-cycle pulse after the final word transfers

module sha3512_digest_reader #(
   parameter int WORD_W    = 64,
   parameter bit BYTE_SWAP = 1'b0
) (
   input  logic              inClk,
   input  logic              inRst,
   input  logic              inInit,
   input  logic              inCapture,
   input  logic [1599:0]     inState,
   output logic              outBusy,
   output logic              outValid,
   output logic [WORD_W-1:0] outData,
   input  logic              inReady,
   output logic              outLast,
   output logic              outDone
);

   localparam int N     = 512 / WORD_W;
   localparam int IDX_W = $clog2(N);
   localparam int BYTES = WORD_W / 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [511:0]     shadow_q, shadow_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             last_q, last_d;
   logic             done_q, done_d;

   logic [WORD_W-1:0] rawWord;
   logic [WORD_W-1:0] outWord;

   // The upper 1088 bits of the state are capacity/rate lanes the digest
   // never uses; fold them into one sink so the intent is explicit.
   logic unusedStateBits;
   assign unusedStateBits = ^inState[1599:512];

   // Next-state logic. inInit overrides everything else and aborts a stream
   // without producing outDone. A capture while streaming is simply ignored,
   // so the shadow register can only change on an IDLE capture edge.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      if (inInit) begin
         state_d  = IDLE;
         shadow_d = '0;
         idx_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (inCapture) begin
                  state_d  = SEND;
                  shadow_d = inState[511:0];
                  idx_d    = '0;
               end
            end
            SEND: begin
               if (inReady) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = IDLE;
                     idx_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
            end
         endcase
      end
      last_d = (state_d == SEND) && (idx_d == LAST_IDX);
   end

   // State, shadow, index and the registered last/done flags.
   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         idx_q    <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         done_q   <= done_d;
      end
   end

   // Output word: a pure mux of registered shadow data by the registered
   // index, optionally byte-reversed. Nothing here depends on inReady.
   always_comb begin
      rawWord = '0;
      for (int k = 0; k < N; k++) begin
         if (idx_q == IDX_W'(k)) begin
            rawWord = shadow_q[WORD_W*k +: WORD_W];
         end
      end
      outWord = rawWord;
      if (BYTE_SWAP) begin
         for (int b = 0; b < BYTES; b++) begin
            outWord[8*(BYTES-1-b) +: 8] = rawWord[8*b +: 8];
         end
      end
   end

   assign outBusy  = (state_q == SEND);
   assign outValid = (state_q == SEND);
   assign outData  = (state_q == SEND) ? outWord : '0;
   assign outLast  = last_q;
   assign outDone  = done_q;

endmodule

// File: tb/tb_sha3512_digest_reader.sv
// Testbench for sha3512_digest_reader.
// Three instances share stimulus: dutA (64-bit, no swap) is tracked by a
// scoreboard monitor; dutB (64-bit, swap) and dutC (32-bit, swap) are checked
// inline by the byte-swap scenario.

module tb_sha3512_digest_reader;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } expEntry_t;

   logic          inClk = 1'b0;
   logic          inRst;
   logic          inInit;
   logic          inCapture;
   logic          inReady;
   logic [1599:0] inState;

   logic        busyA, validA, lastA, doneA;
   logic [63:0] dataA;
   logic        busyB, validB, lastB, doneB;
   logic [63:0] dataB;
   logic        busyC, validC, lastC, doneC;
   logic [31:0] dataC;

   expEntry_t expQ[$];
   int        nCompared   = 0;
   int        nMismatched = 0;
   int        doneCount   = 0;
   int        xferCount   = 0;
   bit        donePending = 1'b0;

   sha3512_digest_reader #(.WORD_W(64), .BYTE_SWAP(1'b0)) dutA (
      .inClk(inClk), .inRst(inRst), .inInit(inInit), .inCapture(inCapture),
      .inState(inState), .outBusy(busyA), .outValid(validA), .outData(dataA),
      .inReady(inReady), .outLast(lastA), .outDone(doneA)
   );

   sha3512_digest_reader #(.WORD_W(64), .BYTE_SWAP(1'b1)) dutB (
      .inClk(inClk), .inRst(inRst), .inInit(inInit), .inCapture(inCapture),
      .inState(inState), .outBusy(busyB), .outValid(validB), .outData(dataB),
      .inReady(inReady), .outLast(lastB), .outDone(doneB)
   );

   sha3512_digest_reader #(.WORD_W(32), .BYTE_SWAP(1'b1)) dutC (
      .inClk(inClk), .inRst(inRst), .inInit(inInit), .inCapture(inCapture),
      .inState(inState), .outBusy(busyC), .outValid(validC), .outData(dataC),
      .inReady(inReady), .outLast(lastC), .outDone(doneC)
   );

   always #5 inClk = ~inClk;

   function automatic logic [1599:0] makeLaneState();
      logic [1599:0] s;
      for (int i = 0; i < 25; i++) begin
         s[64*i +: 64] = 64'h0101010101010101 * 64'(i + 1);
      end
      return s;
   endfunction

   function automatic logic [1599:0] makeRandomState();
      logic [1599:0] s;
      for (int i = 0; i < 50; i++) begin
         s[32*i +: 32] = $urandom;
      end
      return s;
   endfunction

   function automatic logic [63:0] swap64(input logic [63:0] w);
      logic [63:0] r;
      r = {<<8{w}};
      return r;
   endfunction

   function automatic logic [31:0] swap32(input logic [31:0] w);
      logic [31:0] r;
      r = {<<8{w}};
      return r;
   endfunction

   // Drive a one-cycle capture starting at posedge+1; optionally push the
   // digest that dutA is expected to stream onto the scoreboard.
   task automatic pulseCapture(input logic [1599:0] s, input bit push);
      expEntry_t e;
      inState   = s;
      inCapture = 1'b1;
      if (push) begin
         for (int k = 0; k < 8; k++) begin
            e.data = s[64*k +: 64];
            e.last = (k == 7);
            expQ.push_back(e);
         end
      end
      @(posedge inClk); #1;
      inCapture = 1'b0;
   endtask

   task automatic flushScoreboard();
      expQ.delete();
      donePending = 1'b0;
   endtask

   // Bounded wait for the scoreboard to empty and the pending outDone to be seen.
   task automatic waitStreamDrain(input int budget, input string tag);
      int cyc;
      cyc = 0;
      while ((expQ.size() != 0 || donePending) && cyc < budget) begin
         @(posedge inClk); #1;
         cyc++;
      end
      if (expQ.size() != 0 || donePending) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL %s drain timeout: %0d words left, required 0", tag, expQ.size());
         flushScoreboard();
      end
   endtask

   // Scoreboard monitor for dutA, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge inClk);
         if (inRst !== 1'b1) begin
            nCompared++;
            if (doneA !== donePending) begin
               nMismatched++;
               $display("[TB] FAIL mon_done: got %b, required %b", doneA, donePending);
            end
            if (doneA === 1'b1) doneCount++;
            donePending = 1'b0;
            if (validA === 1'b1) begin
               nCompared++;
               if (expQ.size() == 0) begin
                  nMismatched++;
                  $display("[TB] FAIL mon_spurious: valid word %h with no digest outstanding", dataA);
               end else begin
                  if (dataA !== expQ[0].data) begin
                     nMismatched++;
                     $display("[TB] FAIL mon_data: got %h, required %h", dataA, expQ[0].data);
                  end
                  nCompared++;
                  if (lastA !== expQ[0].last) begin
                     nMismatched++;
                     $display("[TB] FAIL mon_last: got %b, required %b", lastA, expQ[0].last);
                  end
                  if (inReady === 1'b1 && inInit !== 1'b1) begin
                     if (expQ[0].last) donePending = 1'b1;
                     void'(expQ.pop_front());
                     xferCount++;
                  end
               end
            end else begin
               nCompared++;
               if (dataA !== 64'h0 || lastA !== 1'b0) begin
                  nMismatched++;
                  $display("[TB] FAIL mon_idle: data %h last %b, required 0 0", dataA, lastA);
               end
            end
         end
      end
   end

   task automatic test_reset();
      #2;
      nCompared++;
      if ({busyA, validA, lastA, doneA} !== 4'b0 || dataA !== 64'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_held: busy/valid/last/done %b%b%b%b data %h, required 0000 0", busyA, validA, lastA, doneA, dataA);
      end
      @(posedge inClk); #1;
      inRst = 1'b0;
      @(posedge inClk); #1;
      nCompared++;
      if ({busyA, validA, lastA, doneA, validC} !== 5'b0 || dataC !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_released: flags %b%b%b%b%b dataC %h, required 00000 0", busyA, validA, lastA, doneA, validC, dataC);
      end
   endtask

   task automatic test_basic_stream();
      int x0, d0;
      logic [63:0] expWord;
      x0 = xferCount;
      d0 = doneCount;
      inReady = 1'b1;
      pulseCapture(makeLaneState(), 1'b1);
      for (int k = 0; k < 8; k++) begin
         expWord = 64'h0101010101010101 * 64'(k + 1);
         nCompared++;
         if (validA !== 1'b1 || busyA !== 1'b1 || dataA !== expWord || lastA !== (k == 7)) begin
            nMismatched++;
            $display("[TB] FAIL basic_word%0d: valid %b busy %b data %h last %b, required 1 1 %h %b", k, validA, busyA, dataA, lastA, expWord, (k == 7));
         end
         @(posedge inClk); #1;
      end
      nCompared++;
      if (doneA !== 1'b1 || validA !== 1'b0 || busyA !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL basic_done_cycle: done %b valid %b busy %b, required 1 0 0", doneA, validA, busyA);
      end
      waitStreamDrain(20, "basic");
      nCompared++;
      if (xferCount - x0 != 8 || doneCount - d0 != 1) begin
         nMismatched++;
         $display("[TB] FAIL basic_counts: transfers %0d dones %0d, required 8 1", xferCount - x0, doneCount - d0);
      end
   endtask

   task automatic test_backpressure();
      int x0, d0, cyc;
      x0 = xferCount;
      d0 = doneCount;
      cyc = 0;
      inReady = 1'b1;
      pulseCapture(makeLaneState(), 1'b1);
      while ((expQ.size() != 0 || donePending) && cyc < 80) begin
         inReady = (cyc % 4 == 0) || (cyc % 4 == 3);
         @(posedge inClk); #1;
         cyc++;
      end
      inReady = 1'b1;
      if (expQ.size() != 0 || donePending) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL bp_timeout: %0d words left, required 0", expQ.size());
         flushScoreboard();
      end
      nCompared++;
      if (xferCount - x0 != 8) begin
         nMismatched++;
         $display("[TB] FAIL bp_transfers: got %0d, required 8", xferCount - x0);
      end
      nCompared++;
      if (doneCount - d0 != 1) begin
         nMismatched++;
         $display("[TB] FAIL bp_done_count: got %0d, required 1", doneCount - d0);
      end
   endtask

   task automatic test_byte_swap();
      logic [1599:0] s;
      s = makeRandomState();
      s[63:0]   = 64'h0011223344556677;
      s[127:64] = 64'h8899aabbccddeeff;
      inReady = 1'b1;
      pulseCapture(s, 1'b1);
      nCompared++;
      if (dataB !== 64'h7766554433221100 || dataC !== 32'h77665544) begin
         nMismatched++;
         $display("[TB] FAIL swap_first: dataB %h dataC %h, required 7766554433221100 77665544", dataB, dataC);
      end
      for (int k = 0; k < 16; k++) begin
         nCompared++;
         if (validC !== 1'b1 || dataC !== swap32(s[32*k +: 32]) || lastC !== (k == 15)) begin
            nMismatched++;
            $display("[TB] FAIL swap32_word%0d: valid %b data %h last %b, required 1 %h %b", k, validC, dataC, lastC, swap32(s[32*k +: 32]), (k == 15));
         end
         if (k == 1) begin
            nCompared++;
            if (dataC !== 32'h33221100) begin
               nMismatched++;
               $display("[TB] FAIL swap32_second: got %h, required 33221100", dataC);
            end
         end
         if (k < 8) begin
            nCompared++;
            if (validB !== 1'b1 || dataB !== swap64(s[64*k +: 64])) begin
               nMismatched++;
               $display("[TB] FAIL swap64_word%0d: valid %b data %h, required 1 %h", k, validB, dataB, swap64(s[64*k +: 64]));
            end
         end
         @(posedge inClk); #1;
      end
      nCompared++;
      if (doneC !== 1'b1 || validC !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL swap32_done: done %b valid %b, required 1 0", doneC, validC);
      end
      waitStreamDrain(20, "swap");
   endtask

   task automatic test_capture_busy();
      int x0, d0, cyc;
      logic [1599:0] sNew;
      x0 = xferCount;
      d0 = doneCount;
      inReady = 1'b1;
      pulseCapture(makeLaneState(), 1'b1);
      repeat (2) begin
         @(posedge inClk); #1;
      end
      // Ignored capture with a different state; the state stays changed.
      pulseCapture(makeRandomState(), 1'b0);
      cyc = 0;
      while (doneA !== 1'b1 && cyc < 20) begin
         @(posedge inClk); #1;
         cyc++;
      end
      nCompared++;
      if (doneA !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL busy_no_done: outDone %b, required 1", doneA);
      end
      sNew = makeRandomState();
      pulseCapture(sNew, 1'b1);
      nCompared++;
      if (validA !== 1'b1 || dataA !== sNew[63:0]) begin
         nMismatched++;
         $display("[TB] FAIL busy_restart: valid %b data %h, required 1 %h", validA, dataA, sNew[63:0]);
      end
      waitStreamDrain(30, "busy");
      nCompared++;
      if (xferCount - x0 != 16 || doneCount - d0 != 2) begin
         nMismatched++;
         $display("[TB] FAIL busy_counts: transfers %0d dones %0d, required 16 2", xferCount - x0, doneCount - d0);
      end
   endtask

   task automatic test_abort_reset();
      int x0, d0;
      d0 = doneCount;
      inReady = 1'b1;
      // inInit while word 4 is presented.
      pulseCapture(makeLaneState(), 1'b1);
      repeat (4) begin
         @(posedge inClk); #1;
      end
      inInit = 1'b1;
      @(posedge inClk); #1;
      inInit = 1'b0;
      flushScoreboard();
      nCompared++;
      if (validA !== 1'b0 || busyA !== 1'b0 || dataA !== 64'h0 || lastA !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL init_abort: valid %b busy %b data %h last %b, required 0 0 0 0", validA, busyA, dataA, lastA);
      end
      repeat (3) begin
         @(posedge inClk); #1;
      end
      nCompared++;
      if (doneCount != d0) begin
         nMismatched++;
         $display("[TB] FAIL init_no_done: dones %0d, required 0", doneCount - d0);
      end
      x0 = xferCount;
      pulseCapture(makeRandomState(), 1'b1);
      waitStreamDrain(20, "after_init");
      nCompared++;
      if (xferCount - x0 != 8 || doneCount - d0 != 1) begin
         nMismatched++;
         $display("[TB] FAIL init_restream: transfers %0d dones %0d, required 8 1", xferCount - x0, doneCount - d0);
      end
      // Asynchronous reset mid-cycle while word 2 is presented.
      d0 = doneCount;
      pulseCapture(makeLaneState(), 1'b1);
      repeat (2) begin
         @(posedge inClk); #1;
      end
      #2;
      inRst = 1'b1;
      #1;
      nCompared++;
      if (validA !== 1'b0 || dataA !== 64'h0 || busyA !== 1'b0 || lastA !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rst_async: valid %b data %h busy %b last %b, required 0 0 0 0", validA, dataA, busyA, lastA);
      end
      @(posedge inClk); #1;
      inRst = 1'b0;
      flushScoreboard();
      repeat (3) begin
         @(posedge inClk); #1;
      end
      nCompared++;
      if (doneCount != d0 || validA !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rst_no_done: dones %0d valid %b, required 0 0", doneCount - d0, validA);
      end
      x0 = xferCount;
      pulseCapture(makeRandomState(), 1'b1);
      waitStreamDrain(20, "after_rst");
      nCompared++;
      if (xferCount - x0 != 8 || doneCount - d0 != 1) begin
         nMismatched++;
         $display("[TB] FAIL rst_restream: transfers %0d dones %0d, required 8 1", xferCount - x0, doneCount - d0);
      end
   endtask

   initial begin
      inRst     = 1'b1;
      inInit    = 1'b0;
      inCapture = 1'b0;
      inReady   = 1'b0;
      inState   = '0;
      test_reset();
      test_basic_stream();
      test_backpressure();
      test_byte_swap();
      test_capture_busy();
      test_abort_reset();
      repeat (2) begin
         @(posedge inClk); #1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
